// File: rtl/sha256_msg_padder_pkg.sv
// Shared definitions for the SHA-256 message padder.
// Holds the block/word/digest widths, the SHA-256 initial hash value,
// the padder state encoding, the block-buffer operation codes and a helper
// that picks one byte of the 64-bit big-endian length field.
package sha256_msg_padder_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned DIGEST_W    = 256;
    localparam int unsigned BLOCK_BYTES = BLOCK_W / 8;
    localparam int unsigned LEN_FIELD_W = 64;
    // First byte of the length field inside a block (56).
    localparam int unsigned LEN_BYTE0   = BLOCK_BYTES - LEN_FIELD_W / 8;

    localparam logic [DIGEST_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PAD,
        ST_LEN_BLK,
        ST_REQ,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_FIN
    } pad_state_t;

    typedef enum logic [1:0] {
        BUF_HOLD,
        BUF_WRITE,
        BUF_PAD,
        BUF_LEN_BLK
    } buf_op_t;

    // Byte pos (0..7) of the big-endian length field; pos 0 is the MSB.
    function automatic logic [7:0] len_byte(input logic [LEN_FIELD_W-1:0] bit_len,
                                            input int unsigned pos);
        return bit_len[8*(7-pos) +: 8];
    endfunction

endpackage

// File: rtl/sha256_msg_padder_block_buf.sv
// sha256_block_buf: 64-byte block buffer for the SHA-256 padder.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears all bytes)
//   op          BUF_HOLD / BUF_WRITE / BUF_PAD / BUF_LEN_BLK
//   idx         byte index used by BUF_WRITE and BUF_PAD
//   data        byte written by BUF_WRITE
//   with_len    BUF_PAD also inserts the length into bytes 56..63
//   bit_len     64-bit message length in bits
//   block       buffer contents, byte 0 at [511:504]
module sha256_block_buf
    import sha256_msg_padder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  buf_op_t            op,
    input  logic [5:0]         idx,
    input  logic [7:0]         data,
    input  logic               with_len,
    input  logic [63:0]        bit_len,
    output logic [BLOCK_W-1:0] block
);

    logic [7:0] mem_q [BLOCK_BYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (op)
                BUF_WRITE: mem_q[idx] <= data;
                BUF_PAD: begin
                    // Bytes below idx are message data and stay untouched.
                    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                        if (i == 32'(idx)) begin
                            mem_q[i] <= 8'h80;
                        end else if (i > 32'(idx)) begin
                            if (with_len && (i >= LEN_BYTE0)) begin
                                mem_q[i] <= len_byte(bit_len, i - LEN_BYTE0);
                            end else begin
                                mem_q[i] <= '0;
                            end
                        end
                    end
                end
                BUF_LEN_BLK: begin
                    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                        if (i >= LEN_BYTE0) begin
                            mem_q[i] <= len_byte(bit_len, i - LEN_BYTE0);
                        end else begin
                            mem_q[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        block = '0;
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
            block[8*(BLOCK_BYTES-1-i) +: 8] = mem_q[i];
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: byte-stream front end for a SHA-256 compression core.
// Builds 512-bit blocks from message bytes, applies 0x80 / zero fill / 64-bit
// big-endian bit length, drives the core's level start handshake and returns
// the final digest with a one-cycle valid pulse.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_empty/s_ready   message byte stream
//   core_start, core_first_run, core_block  request to the core
//   core_ready, core_hash                   completion and state from the core
//   digest, digest_valid        final hash and its one-cycle pulse
//   busy                        high from the first message beat until digest_valid
module sha256_msg_padder
    import sha256_msg_padder_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    input  logic                s_empty,
    output logic                s_ready,
    output logic                core_start,
    output logic                core_first_run,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic                core_ready,
    input  logic [DIGEST_W-1:0] core_hash,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy
);

    localparam logic [LEN_W-1:0] BYTE_BITS = LEN_W'(8);

    pad_state_t state_q, state_d;
    // Where a non-final block continues once the core has finished it.
    pad_state_t after_q, after_d;
    logic [5:0] idx_q, idx_d;
    logic [LEN_W-1:0] bits_q, bits_d;
    logic first_q, first_d;
    logic final_q, final_d;
    logic busy_q, busy_d;
    logic [DIGEST_W-1:0] digest_q;
    logic digest_valid_q;
    logic load_digest;

    buf_op_t buf_op;
    logic buf_with_len;
    logic [63:0] bit_len;

    assign bit_len = 64'(bits_q);

    sha256_block_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (buf_op),
        .idx      (idx_q),
        .data     (s_data),
        .with_len (buf_with_len),
        .bit_len  (bit_len),
        .block    (core_block)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FILL;
            after_q        <= ST_FILL;
            idx_q          <= '0;
            bits_q         <= '0;
            first_q        <= 1'b1;
            final_q        <= 1'b0;
            busy_q         <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            after_q        <= after_d;
            idx_q          <= idx_d;
            bits_q         <= bits_d;
            first_q        <= first_d;
            final_q        <= final_d;
            busy_q         <= busy_d;
            digest_valid_q <= load_digest;
            if (load_digest) begin
                digest_q <= core_hash;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        after_d      = after_q;
        idx_d        = idx_q;
        bits_d       = bits_q;
        first_d      = first_q;
        final_d      = final_q;
        busy_d       = busy_q;
        buf_op       = BUF_HOLD;
        buf_with_len = 1'b0;
        load_digest  = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (s_valid && !s_empty) begin
                    buf_op = BUF_WRITE;
                    bits_d = bits_q + BYTE_BITS;
                    busy_d = 1'b1;
                    idx_d  = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        // Full block goes out as non-final; a last byte here
                        // defers padding to a fresh block afterwards.
                        final_d = 1'b0;
                        after_d = s_last ? ST_PAD : ST_FILL;
                        state_d = ST_REQ;
                    end else if (s_last) begin
                        state_d = ST_PAD;
                    end
                end else if (s_valid && s_last) begin
                    busy_d  = 1'b1;
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                buf_op = BUF_PAD;
                idx_d  = '0;
                if (idx_q <= 6'd55) begin
                    buf_with_len = 1'b1;
                    final_d      = 1'b1;
                end else begin
                    final_d = 1'b0;
                    after_d = ST_LEN_BLK;
                end
                state_d = ST_REQ;
            end
            ST_LEN_BLK: begin
                buf_op  = BUF_LEN_BLK;
                final_d = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                // A ready left over from the previous block must clear first.
                if (!core_ready) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (core_ready) begin
                    first_d = 1'b0;
                    state_d = final_q ? ST_FIN : after_q;
                end
            end
            ST_FIN: begin
                load_digest = 1'b1;
                bits_d      = '0;
                first_d     = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign s_ready        = rst_n && (state_q == ST_FILL);
    assign core_start     = (state_q == ST_REQ) || (state_q == ST_WAIT_LO) ||
                            (state_q == ST_WAIT_HI);
    assign core_first_run = core_start && first_q;
    assign digest         = digest_q;
    assign digest_valid   = digest_valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;
    import sha256_msg_padder_pkg::*;

    localparam int LAT = 8;
    localparam int TMO = 3000;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};

    typedef byte unsigned bq_t[$];

    typedef struct {
        string        name;
        string        msg;
        bit           empty;
        logic [255:0] dig;
        int           nblk;
        logic [63:0]  len;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic s_valid = 1'b0, s_last = 1'b0, s_empty = 1'b0;
    logic s_ready, core_start, core_first_run, core_ready, digest_valid, busy;
    logic [511:0] core_block;
    logic [255:0] core_hash, digest;

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_empty        (s_empty),
        .s_ready        (s_ready),
        .core_start     (core_start),
        .core_first_run (core_first_run),
        .core_block     (core_block),
        .core_ready     (core_ready),
        .core_hash      (core_hash),
        .digest         (digest),
        .digest_valid   (digest_valid),
        .busy           (busy)
    );

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1, ch, mj;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            ch = (e & f) ^ (~e & g);
            t1 = h + s1 + ch + K[t] + w[t];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            mj = (a & b) ^ (a & c) ^ (b & c);
            t2 = s0 + mj;
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [255:0] sw_sha256(input bq_t m);
        bq_t q;
        logic [63:0] bl;
        logic [511:0] blk;
        logic [255:0] h;
        q = m;
        bl = 64'(m.size()) * 64'd8;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        for (int i = 0; i < 8; i++) q.push_back(bl[63-8*i -: 8]);
        h = SHA256_IV;
        for (int bk = 0; bk < q.size() / 64; bk++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = q[64*bk+j];
            h = compress(h, blk);
        end
        return h;
    endfunction

    function automatic bq_t str_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Core model: level start, ready drops on accepting a block and stays
    // high after completion until the next start (the stale-ready case).
    int cm_phase = 0;
    int cm_cnt = 0;
    logic [511:0] cm_blk = '0;
    logic cm_first = 1'b0;
    int blk_cnt = 0;
    logic [7:0] first_bits = '0;
    logic [511:0] last_blk = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready <= 1'b0;
            core_hash  <= '0;
            cm_phase   <= 0;
            cm_cnt     <= 0;
        end else begin
            case (cm_phase)
                0: if (core_start) begin
                    core_ready <= 1'b0;
                    cm_blk     <= core_block;
                    cm_first   <= core_first_run;
                    cm_cnt     <= LAT;
                    cm_phase   <= 1;
                    blk_cnt    <= blk_cnt + 1;
                    first_bits <= {first_bits[6:0], core_first_run};
                    last_blk   <= core_block;
                end
                1: if (cm_cnt == 0) begin
                    core_hash  <= compress(cm_first ? SHA256_IV : core_hash, cm_blk);
                    core_ready <= 1'b1;
                    cm_phase   <= 2;
                end else begin
                    cm_cnt <= cm_cnt - 1;
                end
                default: if (!core_start) cm_phase <= 0;
            endcase
        end
    end

    logic [255:0] dq[$];
    int dv_run = 0, pulse_err = 0, stab_err = 0;
    logic prev_start = 1'b0, prev_first = 1'b0;
    logic [511:0] prev_blk = '0;

    always @(negedge clk) begin
        if (digest_valid) begin
            dq.push_back(digest);
            dv_run = dv_run + 1;
            if (dv_run > 1) pulse_err = pulse_err + 1;
        end else begin
            dv_run = 0;
        end
        if (rst_n && prev_start && core_start &&
            (core_block !== prev_blk || core_first_run !== prev_first))
            stab_err = stab_err + 1;
        prev_start = core_start;
        prev_blk   = core_block;
        prev_first = core_first_run;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int g;
        s_data = d; s_valid = 1'b1; s_last = last; s_empty = empty;
        g = 0;
        @(negedge clk);
        while (!s_ready && g < TMO) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_timeout: s_ready=0 after %0d cycles, want 1", g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input bq_t m, input logic empty, input logic release_valid);
        if (empty) send_beat(8'h00, 1'b1, 1'b1);
        else for (int i = 0; i < m.size(); i++) send_beat(m[i], i == m.size() - 1, 1'b0);
        if (release_valid) begin
            s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
        end
    endtask

    task automatic get_digest(input string nm, output logic [255:0] d);
        int g;
        g = 0;
        while (dq.size() == 0 && g < TMO) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (dq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: no digest_valid after %0d cycles, want a pulse", nm, g);
            d = '0;
        end else begin
            d = dq.pop_front();
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_s_ready"}, s_ready, 0);
        check({pfx, "_core_start"}, core_start, 0);
        check({pfx, "_core_first_run"}, core_first_run, 0);
        check({pfx, "_core_block"}, core_block, 0);
        check({pfx, "_digest"}, digest, 0);
        check({pfx, "_digest_valid"}, digest_valid, 0);
        check({pfx, "_busy"}, busy, 0);
    endtask

    vec_t tv[5];

    initial begin
        string s55, s64;
        logic [255:0] d, d2;
        int nb0, g;
        logic [7:0] fb_mask, fb_exp;

        s55 = ""; s64 = "";
        for (int i = 0; i < 55; i++) s55 = {s55, "a"};
        for (int i = 0; i < 64; i++) s64 = {s64, "a"};

        tv[0].name = "abc";   tv[0].msg = "abc"; tv[0].empty = 1'b0;
        tv[0].dig = DIG_ABC;   tv[0].nblk = 1; tv[0].len = 64'h18;
        tv[1].name = "empty"; tv[1].msg = "";    tv[1].empty = 1'b1;
        tv[1].dig = DIG_EMPTY; tv[1].nblk = 1; tv[1].len = 64'h0;
        tv[2].name = "msg56"; tv[2].msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        tv[2].empty = 1'b0; tv[2].dig = DIG_56; tv[2].nblk = 2; tv[2].len = 64'h1c0;
        tv[3].name = "a55";   tv[3].msg = s55;   tv[3].empty = 1'b0;
        tv[3].dig = sw_sha256(str_q(s55)); tv[3].nblk = 1; tv[3].len = 64'h1b8;
        tv[4].name = "a64";   tv[4].msg = s64;   tv[4].empty = 1'b0;
        tv[4].dig = sw_sha256(str_q(s64)); tv[4].nblk = 2; tv[4].len = 64'h200;

        // Reset values while held in reset, then s_ready rises afterwards.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_s_ready", s_ready, 1);
        check("post_reset_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            nb0 = blk_cnt;
            send_msg(str_q(tv[i].msg), tv[i].empty, 1'b1);
            get_digest(tv[i].name, d);
            check({tv[i].name, "_digest"}, d, tv[i].dig);
            check({tv[i].name, "_blocks"}, blk_cnt - nb0, tv[i].nblk);
            fb_mask = 8'((1 << tv[i].nblk) - 1);
            fb_exp  = 8'(1 << (tv[i].nblk - 1));
            check({tv[i].name, "_first_run"}, first_bits & fb_mask, fb_exp);
            check({tv[i].name, "_len_field"}, last_blk[63:0], tv[i].len);
            check({tv[i].name, "_busy_after"}, busy, 0);
        end

        // s_empty without s_last is ignored; busy rises on the first byte.
        send_beat(8'h5a, 1'b0, 1'b1);
        send_beat("a", 1'b0, 1'b0);
        check("busy_first_beat", busy, 1);
        send_beat("b", 1'b0, 1'b0);
        send_beat("c", 1'b1, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        get_digest("ignored_empty", d);
        check("ignored_empty_digest", d, DIG_ABC);
        check("abc_block_image", last_blk, ABC_BLK);

        // Back-to-back messages with s_valid held high.
        nb0 = blk_cnt;
        send_msg(str_q("abc"), 1'b0, 1'b0);
        send_msg(str_q("abc"), 1'b0, 1'b1);
        get_digest("b2b_1", d);
        get_digest("b2b_2", d2);
        check("b2b_digest1", d, DIG_ABC);
        check("b2b_digest2", d2, DIG_ABC);
        check("b2b_blocks", blk_cnt - nb0, 2);
        check("b2b_first_run", first_bits[1:0], 2'b11);

        // Reset while waiting for the core to finish.
        send_msg(str_q("abc"), 1'b0, 1'b1);
        g = 0;
        while (!(cm_phase == 1 && cm_cnt <= LAT - 3) && g < TMO) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("wait_hi_start_held", core_start, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dq.delete();
        @(posedge clk);
        #1;
        check("mid_reset_s_ready_after", s_ready, 1);
        nb0 = blk_cnt;
        send_msg(str_q("abc"), 1'b0, 1'b1);
        get_digest("after_reset", d);
        check("after_reset_digest", d, DIG_ABC);
        check("after_reset_blocks", blk_cnt - nb0, 1);
        check("after_reset_first_run", first_bits[0], 1);

        check("block_stable_while_start", stab_err, 0);
        check("digest_valid_one_cycle", pulse_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Front-end initiator for the SHA-256 compression core. Accepts a byte stream per message and builds 512-bit blocks. Applies FIPS 180-4 padding: 0x80, zero fill, then the 64-bit big-endian bit length. Drives the core's start/first_run/block_in level handshake, then returns the final digest with a one-cycle valid pulse.

Parameters:
LEN_W, 64, width of the internal bit-length counter (legal range 16..64); the length field is always 64 bits, zero-extended above LEN_W; the counter wraps modulo 2^LEN_W.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
s_data  in  8  message byte
s_valid  in  1  byte/marker valid
s_last  in  1  qualifies the final beat of a message
s_empty  in  1  with s_valid&s_last: beat carries no byte (zero-length tail/empty message)
s_ready  out  1  padder accepts a beat this cycle
core_start  out  1  level start to core
core_first_run  out  1  1 on the first block of a message (core loads IV)
core_block  out  512  block to core; the first byte of the block is at [511:504]
core_ready  in  1  core completion flag
core_hash  in  256  core state/hash
digest  out  256  final hash, registered from core_hash
digest_valid  out  1  one-cycle pulse when digest is updated
busy  out  1  high from the first accepted beat until digest_valid

Behaviour:
- Reset values: s_ready=0 during reset and =1 after, core_start=0, core_first_run=0, core_block=0, digest=0, digest_valid=0, busy=0. State FILL, byte index idx=0, bit count=0, first flag=1.
- Reset is asynchronous and may arrive mid-operation. All state is cleared. The core is expected to be reset by the same reset.
- States: FILL, PAD, LEN_BLK, REQ, WAIT_LO, WAIT_HI, FIN.
- FILL: s_ready=1.
  - Each accepted beat with a byte writes byte idx, increments idx, and adds 8 to the bit count.
  - idx reaching 64 without s_last -> REQ (normal block, not final). idx resets to 0.
  - Accepted s_last (with or without a byte) -> PAD. If this beat carries a byte that completes the block (idx 63->64), the block is sent first as a normal block, then PAD runs with idx=0.
- PAD (1 cycle): write 0x80 at idx and zero bytes idx+1..63.
  - If idx<=55: write the length into bytes 56..63, mark final, -> REQ.
  - If idx>=56: send as non-final -> REQ, then go to LEN_BLK.
- LEN_BLK (1 cycle): all-zero block with the length in bytes 56..63, final -> REQ.
- REQ: core_start=1, core_first_run=first flag, core_block stable -> WAIT_LO.
- WAIT_LO: hold start until core_ready==0. This guards against a stale ready left over from the previous block.
- WAIT_HI: hold start until core_ready==1. Then drop core_start the same cycle and clear the first flag.
  - Final block -> FIN.
  - Otherwise -> FILL with idx=0.
  - core_start is low for at least 1 cycle between blocks, which lets the core exit its done state.
- FIN: digest<=core_hash, digest_valid=1 for 1 cycle. Clear bit count and set the first flag. -> FILL.
- s_ready=0 in every state except FILL. core_block and core_first_run are held constant while core_start=1.
- Latency: the core plus handshake take about 68 cycles per block. The padding path adds 1 cycle (or 2 with LEN_BLK).
- s_valid&s_last&s_empty as the first beat of a message gives the empty-message digest: one block 0x80, zeros, length 0.
- s_empty without s_last is ignored; no byte is written.

Decomposition:
- Shared package: SHA-256 IV constants, block/word/digest widths, and the padder state encoding.
- One natural sub-module: sha256_block_buf. It holds the 64-byte buffer with byte-index write, zero-fill-from-idx, and length-insert operations. The FSM and handshake stay in the top.

Test Plan:
- "abc" (3 beats, last on 'c') -> one block, first_run=1; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (single beat s_last=1,s_empty=1) -> digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two blocks (PAD then LEN_BLK), first_run 1 then 0; digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 55-byte and 64-byte 'a' messages -> exactly 1 and 2 blocks respectively; the length field reads 0x1B8 and 0x200; digests match the software model.
- Back-to-back "abc" twice with s_valid held high -> two digest_valid pulses, both equal to the "abc" digest; the second message starts with first_run=1.
- rst_n low during WAIT_HI -> all outputs at reset values next cycle; a following "abc" gives the correct digest.
- Core model holding stale core_ready=1 when start rises -> padder waits for the 0 then the 1; core_start low for at least 1 cycle between blocks.
